axis_packet_fifo: RTL and testbench
===================================

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the axis_data fields.
REQ-002 SHALL have parameter ID_W, default 4: width of the axis_id fields.
REQ-003 SHALL have parameter DEPTH, default 16: number of entries; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports s_axis_data (DATA_W), s_axis_id (ID_W), s_axis_valid (1) and s_axis_last (1), all inputs: slave stream.
REQ-007 SHALL have port s_axis_ready, output, 1: slave stream ready.
REQ-008 SHALL have ports m_axis_data (DATA_W), m_axis_id (ID_W), m_axis_valid (1) and m_axis_last (1), all outputs: master stream.
REQ-009 SHALL have port m_axis_ready, input, 1: master stream ready.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1: current entry count, 0..DEPTH.

Function
REQ-011 SHALL store {data, id, last} per entry, in a DEPTH-deep circular buffer.
REQ-012 SHALL write one entry on each cycle where s_axis_valid && s_axis_ready.
REQ-013 SHALL read one entry on each cycle where m_axis_valid && m_axis_ready.
REQ-014 SHALL drive s_axis_ready = (level != DEPTH), combinationally from registered state.
  - No write when full, even if a read occurs in the same cycle.
REQ-015 SHALL make a word written at edge N visible on m_axis_* after edge N (valid in cycle N+1); no same-cycle bypass.
REQ-016 SHALL present the head entry on m_axis_data, m_axis_id and m_axis_last.
REQ-017 SHALL hold m_axis_* stable while m_axis_valid && !m_axis_ready.
REQ-018 SHALL update level by +1 on write only, -1 on read only, and 0 on both or neither.
REQ-019 SHALL wrap the write and read pointers modulo DEPTH; full/empty are derived from level, never from pointer equality alone.
REQ-020 SHALL preserve word order and last markers exactly; no reordering or merging across id values.
REQ-021 SHALL hold the buffer and pointers unchanged when s_axis_valid and m_axis_ready are both low for any number of cycles.

Reset
REQ-022 SHALL, while rst is high, force immediately: pointers = 0, level = 0, s_axis_ready = 0, m_axis_valid = 0, packet count = 0, oversize flag = 0.
REQ-023 SHALL leave m_axis_data, m_axis_id and m_axis_last at 0 during reset; storage contents are not reset.
REQ-024 SHALL discard all in-flight words on a reset mid-packet; the first word after reset starts a new packet.
REQ-025 SHALL assert s_axis_ready on the first clk edge after rst deasserts (FIFO empty).

Configuration
REQ-026 SHALL compile store-and-forward packet mode in only when macro AXIS_FIFO_PACKET_MODE_EN is defined.
REQ-027 Without AXIS_FIFO_PACKET_MODE_EN: m_axis_valid = (level != 0) (cut-through FIFO); no packet counter is synthesised.
REQ-028 With AXIS_FIFO_PACKET_MODE_EN: a packet counter SHALL count +1 when a last=1 word is written and -1 when a last=1 word is read.
  - Net 0 when both happen in the same cycle.
REQ-029 With AXIS_FIFO_PACKET_MODE_EN: m_axis_valid = (level != 0) && (pkt_cnt != 0 || oversize).
REQ-030 With AXIS_FIFO_PACKET_MODE_EN: oversize SHALL set when level == DEPTH && pkt_cnt == 0, and clear on the cycle a last=1 word is read.
  - While set, the FIFO runs cut-through to avoid deadlock.

Verification
REQ-031 Bench SHALL cover: DEPTH=4, 3-word burst D0..D2 (last on D2), m_axis_ready=1 -> m_axis_valid first high 1 cycle after D0 accepted (cut-through); in-order output, last only on D2.
REQ-032 Bench SHALL cover: DEPTH=4, m_axis_ready=0, 5 words offered -> s_axis_ready low after the 4th accept, level=4, 5th word held; one read -> 5th word accepted next edge.
REQ-033 Bench SHALL cover: level=2, s_axis_valid=1 and m_axis_ready=1 for 10 cycles -> level stays 2; pointers wrap with no data loss (check 10 sequential values).
REQ-034 Bench SHALL cover: AXIS_FIFO_PACKET_MODE_EN, packet of 3 words id=5 -> m_axis_valid stays 0 until the cycle after the last word is written, then 3 consecutive beats with id=5.
REQ-035 Bench SHALL cover: AXIS_FIFO_PACKET_MODE_EN, DEPTH=4, 6-word packet -> oversize=1 at level=4; words drain cut-through; oversize clears on the last beat read.
REQ-036 Bench SHALL cover: rst pulsed high with level=3 mid-packet -> m_axis_valid=0 and level=0 immediately; after release, a 1-word packet passes with correct data.

Source files
------------

// File: rtl/axis_packet_fifo.sv
// ---------------------------------------------------------------------------
// axis_packet_fifo
//   Purpose     : DEPTH-entry AXI-Stream FIFO storing {data, id, last} per word.
//   Latency     : a word accepted at edge N is presented on m_axis_* in cycle N+1.
//   Backpressure: s_axis_ready drops only when full; m_axis_* hold while stalled.
//
// Build option: define AXIS_FIFO_PACKET_MODE_EN to get store-and-forward
// packet mode. Output is then withheld until a complete packet (last=1) is
// buffered, except when an oversize packet fills the FIFO, which falls back
// to cut-through until its last word leaves.
//
// Ports
//   clk, rst        : single rising-edge clock, asynchronous active-high reset
//   s_axis_*        : input stream (data, id, last, valid / ready)
//   m_axis_*        : output stream (data, id, last, valid / ready)
//   level           : number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_packet_fifo #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [DATA_W-1:0]          s_axis_data,
  input  logic [ID_W-1:0]            s_axis_id,
  input  logic                       s_axis_valid,
  input  logic                       s_axis_last,
  output logic                       s_axis_ready,

  output logic [DATA_W-1:0]          m_axis_data,
  output logic [ID_W-1:0]            m_axis_id,
  output logic                       m_axis_valid,
  output logic                       m_axis_last,
  input  logic                       m_axis_ready,

  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic            ready_en;
  logic            wr_en;
  logic            rd_en;

  // ready_en is cleared by reset and set by the first edge afterwards, so
  // s_axis_ready is low throughout reset and rises one edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Full is taken from the level counter: with power-of-two depth the
  // pointers are equal both when empty and when full.
  assign s_axis_ready = ready_en && (level_q != FULL_LVL);
  assign wr_en        = s_axis_valid && s_axis_ready;
  assign rd_en        = m_axis_valid && m_axis_ready;

  assign wr_entry.data = s_axis_data;
  assign wr_entry.id   = s_axis_id;
  assign wr_entry.last = s_axis_last;

  // Storage is deliberately not reset; only pointers and counters are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign level = level_q;

  // Head entry is read straight from storage; it only changes when rd_ptr
  // advances, so the outputs are stable while stalled. Forced to zero during
  // reset because the storage itself is not cleared.
  assign head        = mem[rd_ptr];
  assign m_axis_data = rst ? '0   : head.data;
  assign m_axis_id   = rst ? '0   : head.id;
  assign m_axis_last = rst ? 1'b0 : head.last;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  // Number of complete packets (buffered last=1 words).
  logic [LW-1:0] pkt_cnt;
  // Set when the FIFO is full with no complete packet inside: the packet
  // can never complete, so release it cut-through until its last word leaves.
  logic          oversize;
  logic          wr_last;
  logic          rd_last;

  assign wr_last = wr_en && s_axis_last;
  assign rd_last = rd_en && head.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oversize <= 1'b0;
    end else if (rd_last) begin
      oversize <= 1'b0;
    end else if ((level_q == FULL_LVL) && (pkt_cnt == '0)) begin
      oversize <= 1'b1;
    end
  end

  assign m_axis_valid = (level_q != '0) && ((pkt_cnt != '0) || oversize);
`else
  assign m_axis_valid = (level_q != '0);
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_fifo
//   Directed scenarios plus a random phase on a DEPTH=4 instance, checked
//   every cycle against a queue-based reference model of the FIFO.
//   Also builds with AXIS_FIFO_PACKET_MODE_EN for the packet-mode scenarios.
// ---------------------------------------------------------------------------
module tb_axis_packet_fifo;

  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_axis_data  = '0;
  logic [IW-1:0] s_axis_id    = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_last  = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic [IW-1:0] m_axis_id;
  logic          m_axis_valid;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b0;
  logic [LW-1:0] level;

  axis_packet_fifo #(.DATA_W(DW), .ID_W(IW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_axis_data),
    .s_axis_id    (s_axis_id),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_id    (m_axis_id),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .level        (level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  beat_t         q[$];
  bit            mdl_rdy_en = 1'b0;
  bit            mdl_ovs    = 1'b0;
  bit            last_wr;
  bit            last_rd;
  logic [DW-1:0] obs_rd_data;
  int            n_chk  = 0;
  int            n_fail = 0;

  function automatic int lasts_in_q();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  function automatic bit mdl_ready();
    return mdl_rdy_en && (q.size() != DEPTH);
  endfunction

  function automatic bit mdl_valid();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    return (q.size() != 0) && ((lasts_in_q() != 0) || mdl_ovs);
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".level"},   64'(level),        64'(q.size()));
    chk({tag, ".s_ready"}, 64'(s_axis_ready), 64'(mdl_ready()));
    chk({tag, ".m_valid"}, 64'(m_axis_valid), 64'(mdl_valid()));
    if (mdl_valid()) begin
      chk({tag, ".m_data"}, 64'(m_axis_data), 64'(q[0].d));
      chk({tag, ".m_id"},   64'(m_axis_id),   64'(q[0].id));
      chk({tag, ".m_last"}, 64'(m_axis_last), 64'(q[0].last));
    end
`ifdef AXIS_FIFO_PACKET_MODE_EN
    chk({tag, ".oversize"}, 64'(dut.oversize), 64'(mdl_ovs));
`endif
  endtask

  task automatic drv(input bit v, input logic [DW-1:0] d, input logic [IW-1:0] id,
                     input bit l, input bit mr);
    s_axis_valid = v;
    s_axis_data  = d;
    s_axis_id    = id;
    s_axis_last  = l;
    m_axis_ready = mr;
  endtask

  // One clock: predict transfers from the model, advance, update, compare.
  task automatic tick(input string tag);
    beat_t b;
    bit    wr;
    bit    rd;
    wr = s_axis_valid && mdl_ready();
    rd = mdl_valid() && m_axis_ready;
    b.d = s_axis_data;
    b.id = s_axis_id;
    b.last = s_axis_last;
    obs_rd_data = m_axis_data;
    @(posedge clk);
    #1;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    if (rd && q[0].last) mdl_ovs = 1'b0;
    else if ((q.size() == DEPTH) && (lasts_in_q() == 0)) mdl_ovs = 1'b1;
`endif
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(b);
    mdl_rdy_en = 1'b1;
    last_wr = wr;
    last_rd = rd;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    q.delete();
    mdl_rdy_en = 1'b0;
    mdl_ovs    = 1'b0;
    chk({tag, ".rst_level"},  64'(level),        64'd0);
    chk({tag, ".rst_sready"}, 64'(s_axis_ready), 64'd0);
    chk({tag, ".rst_mvalid"}, 64'(m_axis_valid), 64'd0);
    chk({tag, ".rst_mdata"},  64'(m_axis_data),  64'd0);
    chk({tag, ".rst_mid"},    64'(m_axis_id),    64'd0);
    chk({tag, ".rst_mlast"},  64'(m_axis_last),  64'd0);
    @(posedge clk);
    #1;
    check_outputs({tag, ".in_rst"});
    rst = 1'b0;
    #1;
    chk({tag, ".sready_before_edge"}, 64'(s_axis_ready), 64'd0);
    drv(0, '0, '0, 0, 0);
    tick({tag, ".release"});
    chk({tag, ".sready_after_edge"}, 64'(s_axis_ready), 64'd1);
  endtask

  initial begin
    int k;
    bit seen;

    #1;
    do_reset("init");

    // 3-word burst D0..D2, last on D2, sink always ready.
    drv(1, 32'hD0, 4'd1, 0, 1); tick("burst0");
`ifndef AXIS_FIFO_PACKET_MODE_EN
    chk("burst.valid_1cyc", 64'(m_axis_valid), 64'd1);
    chk("burst.first_data", 64'(m_axis_data),  64'hD0);
`endif
    drv(1, 32'hD1, 4'd1, 0, 1); tick("burst1");
    drv(1, 32'hD2, 4'd1, 1, 1); tick("burst2");
    for (int i = 0; i < 4; i++) begin
      drv(0, '0, '0, 0, 1); tick("burst_drain");
    end
    chk("burst.empty", 64'(level), 64'd0);

    // Fill to full with sink stalled, 5th word must be held.
    k = 0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      drv(1, 32'h100 + k, 4'd2, 0, 0); tick("fill");
      if (last_wr) k++;
    end
    chk("full.level",  64'(level),        64'd4);
    chk("full.sready", 64'(s_axis_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      drv(1, 32'h104, 4'd2, 1, 0); tick("full_hold");
      chk("full.hold_level", 64'(level), 64'd4);
    end
    drv(1, 32'h104, 4'd2, 1, 1); tick("full_read");
    chk("full.read_no_write", 64'(level),        64'd3);
    chk("full.sready_back",   64'(s_axis_ready), 64'd1);
    drv(1, 32'h104, 4'd2, 1, 0); tick("full_5th");
    chk("full.5th_accepted", 64'(level), 64'd4);
    for (int i = 0; i < 3; i++) begin
      drv(0, '0, '0, 0, 0); tick("idle");
      chk("idle.level", 64'(level), 64'd4);
      chk("idle.head",  64'(m_axis_data), 64'h101);
    end
    for (int i = 0; i < 6; i++) begin
      drv(0, '0, '0, 0, 1); tick("full_drain");
    end
    chk("full.drained", 64'(level), 64'd0);

    // Steady level 2 with simultaneous read/write; pointers wrap.
    drv(1, 32'h200, 4'd3, 1, 0); tick("wrap_pre0");
    drv(1, 32'h201, 4'd3, 1, 0); tick("wrap_pre1");
    chk("wrap.level_start", 64'(level), 64'd2);
    for (int i = 0; i < 10; i++) begin
      drv(1, 32'h202 + i, 4'd3, 1, 1); tick("wrap");
      chk("wrap.level",   64'(level),       64'd2);
      chk("wrap.rd",      64'(last_rd),     64'd1);
      chk("wrap.rd_data", 64'(obs_rd_data), 64'(32'h200 + i));
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, '0, '0, 0, 1); tick("wrap_drain");
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing leaves until the last word is in.
    drv(1, 32'h300, 4'd5, 0, 1); tick("pkt0");
    chk("pkt.hold0", 64'(m_axis_valid), 64'd0);
    drv(1, 32'h301, 4'd5, 0, 1); tick("pkt1");
    chk("pkt.hold1", 64'(m_axis_valid), 64'd0);
    drv(1, 32'h302, 4'd5, 1, 1); tick("pkt2");
    for (int j = 0; j < 3; j++) begin
      chk("pkt.beat_valid", 64'(m_axis_valid), 64'd1);
      chk("pkt.beat_id",    64'(m_axis_id),    64'd5);
      chk("pkt.beat_data",  64'(m_axis_data),  64'(32'h300 + j));
      drv(0, '0, '0, 0, 1); tick("pkt_out");
    end
    chk("pkt.done", 64'(m_axis_valid), 64'd0);

    // Oversize packet: 6 words into a 4-deep FIFO.
    k = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      drv(1, 32'h400 + k, 4'd6, k == 5, 1); tick("ovs");
      if (last_wr) k++;
      if (dut.oversize && !seen) begin
        seen = 1'b1;
        chk("ovs.level_at_set", 64'(level), 64'd4);
      end
    end
    chk("ovs.seen",     64'(seen), 64'd1);
    chk("ovs.all_in",   64'(k),    64'd6);
    for (int i = 0; i < 6; i++) begin
      drv(0, '0, '0, 0, 1); tick("ovs_drain");
    end
    chk("ovs.cleared", 64'(dut.oversize), 64'd0);
    chk("ovs.empty",   64'(level),        64'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      tick("rand");
    end

    // Reset mid-packet with level 3.
    do_reset("pre36");
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h600 + i, 4'd7, 0, 0); tick("mid_pkt");
    end
    chk("mid.level3", 64'(level), 64'd3);
    do_reset("mid");
    drv(1, 32'h5A5A, 4'd9, 1, 1); tick("post_rst_wr");
    chk("post.valid", 64'(m_axis_valid), 64'd1);
    chk("post.data",  64'(m_axis_data),  64'h5A5A);
    chk("post.id",    64'(m_axis_id),    64'd9);
    chk("post.last",  64'(m_axis_last),  64'd1);
    drv(0, '0, '0, 0, 1); tick("post_rst_rd");
    chk("post.empty", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
